// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// ----------------
// EX-stage execution unit for the HI/LO instruction group. It owns the
// architectural HI and LO registers and implements the following operations:
//   - MULT and MULTU: multi-cycle multiplies, MUL_CYCLES busy cycles after accept.
//   - DIV and DIVU: 32-iteration restoring divide, one iteration per cycle.
//   - MTHI and MTLO: single-cycle writes from a_i.
//   - MFHI and MFLO: combinational reads returned on result_o.
// The pipeline is stalled while a multiply or divide is in flight.
//
// Optional build macro: MULDIV_DIV0_FLAG_EN
//   When it is defined, a divide by zero leaves HI/LO unchanged and raises
//   div0_o together with done_o. When it is undefined, there is no div0_o port
//   and a divide by zero writes hi=dividend, lo=32'hFFFFFFFF.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   flush        in   cancel the in-flight operation (squash)
//   valid_i      in   EX-stage instruction valid
//   alucontrol_i in   8-bit ALU operation code
//   a_i, b_i     in   rs / rt operands (32 bit)
//   stall_o      out  pipeline stall request
//   done_o       out  one-cycle pulse when a mul/div result has been written
//   hi_o, lo_o   out  HI / LO registers
//   result_o     out  MFHI -> hi_o, MFLO -> lo_o, otherwise 0 (combinational)
//   div0_o       out  divide-by-zero flag (only with MULDIV_DIV0_FLAG_EN)
module hilo_muldiv_unit #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_i,
  input  logic [7:0]  alucontrol_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] result_o
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic        div0_o
`endif
);

  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, state_nx;
  logic [5:0]  cnt;
  logic        div0_q;
  logic [7:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [31:0] hi_q, lo_q;

  // Two's-complement magnitude when the operand is treated as signed.
  // The magnitude of 0x80000000 is 0x80000000 read as unsigned, which the
  // restoring divider handles correctly.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic is_mul, is_div, accept, mul_last, div_last;

  always_comb begin
    is_mul   = (alucontrol_i == OP_MULT) || (alucontrol_i == OP_MULTU);
    is_div   = (alucontrol_i == OP_DIV)  || (alucontrol_i == OP_DIVU);
    accept   = (state == S_IDLE) && valid_i && !flush && (is_mul || is_div);
    mul_last = (cnt == 6'(MUL_CYCLES - 1));
    div_last = (cnt == 6'(DIV_ITERS - 1));
  end

  // ---- Multiply: full 64-bit product of the latched operands ----
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
  end

  // ---- Divide: one restoring iteration, plus sign fix-up for the final write ----
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_nx, quo_nx;
  logic        a_neg, b_neg;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    rem_ge    = (rem_shift >= {1'b0, dvs_q});
    rem_nx    = rem_ge ? 32'(rem_shift - {1'b0, dvs_q}) : rem_shift[31:0];
    quo_nx    = {quo_q[30:0], rem_ge};
    a_neg     = (op_q == OP_DIV) && a_q[31];
    b_neg     = (op_q == OP_DIV) && b_q[31];
    quo_fix   = neg_if(quo_nx, a_neg ^ b_neg);
    rem_fix   = neg_if(rem_nx, a_neg);
  end

  // ---- Control FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 6'd0;
      div0_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt    <= 6'd0;
        div0_q <= is_div && (b_i == 32'd0);
      end else if (state == S_MUL || state == S_DIV) begin
        cnt <= cnt + 6'd1;
      end
    end
  end

  // ---- Control FSM: next state and outputs ----
  // A flush leaves stall asserted for the current cycle only; the pipeline
  // sees the unit free from the next cycle on.
  always_comb begin
    state_nx = state;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          stall_o  = 1'b1;
          state_nx = is_div ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        stall_o = 1'b1;
        if (flush)         state_nx = S_IDLE;
        else if (mul_last) state_nx = S_DONE;
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (flush)         state_nx = S_IDLE;
        else if (div_last) state_nx = S_DONE;
      end
      S_DONE: begin
        done_o   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---- Operand latch and divider iteration registers ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= alucontrol_i;
      a_q   <= a_i;
      b_q   <= b_i;
      rem_q <= 32'd0;
      quo_q <= abs_if(a_i, alucontrol_i == OP_DIV);
      dvs_q <= abs_if(b_i, alucontrol_i == OP_DIV);
    end else if (state == S_DIV) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  // ---- Architectural HI/LO write-back ----
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state == S_IDLE) begin
      if (valid_i && !flush) begin
        if (alucontrol_i == OP_MTHI) hi_q <= a_i;
        if (alucontrol_i == OP_MTLO) lo_q <= a_i;
      end
    end else if (state == S_MUL && !flush && mul_last) begin
      if (op_q == OP_MULT) {hi_q, lo_q} <= prod_s;
      else                 {hi_q, lo_q} <= prod_u;
    end else if (state == S_DIV && !flush && div_last) begin
      if (div0_q) begin
`ifndef MULDIV_DIV0_FLAG_EN
        hi_q <= a_q;
        lo_q <= 32'hFFFF_FFFF;
`endif
      end else begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end
    end
  end

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (alucontrol_i == OP_MFHI)      result_o = hi_q;
    else if (alucontrol_i == OP_MFLO) result_o = lo_q;
    else                              result_o = 32'd0;
  end

`ifdef MULDIV_DIV0_FLAG_EN
  assign div0_o = (state == S_DONE) && div0_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
// -------------------
// Directed testbench for hilo_muldiv_unit. The bench contains an arithmetic
// reference model of HI/LO and of the busy window. The model computes
// products and quotients directly with 64-bit integer operators. A compare
// process checks every output on every falling edge. Hand-computed literal
// expectations pin both the model and the DUT.
module tb_hilo_muldiv_unit;

  localparam int MUL_CYCLES = 2;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic        clk = 1'b0;
  logic        rst, flush, valid_i;
  logic [7:0]  alucontrol_i;
  logic [31:0] a_i, b_i;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o, result_o;
  logic        div0_w;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITERS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .valid_i     (valid_i),
    .alucontrol_i(alucontrol_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .result_o    (result_o)
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    .div0_o      (div0_w)
`endif
  );

`ifndef MULDIV_DIV0_FLAG_EN
  assign div0_w = 1'b0;
`endif

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_busy;
  bit          m_done, m_pwr, m_pdiv0, m_div0;

  function automatic bit is_muldiv(input logic [7:0] c);
    return (c == OP_MULT) || (c == OP_MULTU) || (c == OP_DIV) || (c == OP_DIVU);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_div0 = 0;
    end else if (m_done) begin
      m_done = 0;
      m_div0 = 0;
    end else if (m_busy > 0) begin
      if (flush) m_busy = 0;
      else begin
        m_busy--;
        if (m_busy == 0) begin
          if (m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
          m_done = 1;
          m_div0 = m_pdiv0;
        end
      end
    end else if (valid_i && !flush) begin
      longint sa, sb, p, q, r;
      longint unsigned ua, ub, pu;
      sa = longint'($signed(a_i));
      sb = longint'($signed(b_i));
      ua = longint'(a_i);
      ub = longint'(b_i);
      m_pwr = 1; m_pdiv0 = 0;
      case (alucontrol_i)
        OP_MTHI: m_hi = a_i;
        OP_MTLO: m_lo = a_i;
        OP_MULT: begin
          p = sa * sb; m_phi = 32'(p >>> 32); m_plo = 32'(p); m_busy = MUL_CYCLES;
        end
        OP_MULTU: begin
          pu = ua * ub; m_phi = 32'(pu >> 32); m_plo = 32'(pu); m_busy = MUL_CYCLES;
        end
        OP_DIV, OP_DIVU: begin
          m_busy = 32;
          if (b_i == 0) begin
`ifdef MULDIV_DIV0_FLAG_EN
            m_pwr = 0; m_pdiv0 = 1;
`else
            m_phi = a_i; m_plo = 32'hFFFF_FFFF;
`endif
          end else if (alucontrol_i == OP_DIV) begin
            q = sa / sb; r = sa % sb; m_phi = 32'(r); m_plo = 32'(q);
          end else begin
            m_phi = 32'(ua % ub); m_plo = 32'(ua / ub);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_stall;
      logic [31:0] e_res;
      e_stall = (m_busy > 0) ||
                (!m_done && valid_i && !flush && !rst && is_muldiv(alucontrol_i));
      e_res = (alucontrol_i == OP_MFHI) ? m_hi :
              (alucontrol_i == OP_MFLO) ? m_lo : 32'd0;
      check("cyc_stall", 64'(stall_o), 64'(e_stall));
      check("cyc_done",  64'(done_o),  64'(m_done));
      check("cyc_hi",    64'(hi_o),    64'(m_hi));
      check("cyc_lo",    64'(lo_o),    64'(m_lo));
      check("cyc_result", 64'(result_o), 64'(e_res));
`ifdef MULDIV_DIV0_FLAG_EN
      check("cyc_div0",  64'(div0_w),  64'(m_done && m_div0));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] a, input logic [31:0] b);
    valid_i = v; alucontrol_i = c; a_i = a; b_i = b;
  endtask

  // Presents one mul/div instruction and holds it until the done pulse.
  // The instruction is then dropped once the unit is back in IDLE.
  task automatic run_op(input logic [7:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output bit got, output logic [31:0] h,
                        output logic [31:0] l, output logic d0);
    drive(1'b1, c, a, b);
    stalls = 0; got = 0; h = 0; l = 0; d0 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (done_o) begin
        got = 1; h = hi_o; l = lo_o; d0 = div0_w;
        break;
      end
    end
    step(1);
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
  endtask

  int          st;
  bit          got, seen;
  logic [31:0] h, l;
  logic        d0;

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    step(2);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    step(1);
    rst = 1'b0;
    step(1);

    // MULT -3 * 7
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, st, got, h, l, d0);
    check("mult_done", 64'(got), 64'd1);
    check("mult_stalls", 64'(st), 64'd3);
    check("mult_hi", 64'(h), 64'hFFFF_FFFF);
    check("mult_lo", 64'(l), 64'hFFFF_FFEB);

    // MULTU max * max, followed immediately by another MULTU
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, got, h, l, d0);
    check("multu_hi", 64'(h), 64'hFFFF_FFFE);
    check("multu_lo", 64'(l), 64'h0000_0001);
    run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0003, st, got, h, l, d0);
    check("multu2_stalls", 64'(st), 64'd3);
    check("multu2_hi", 64'(h), 64'h0000_0001);
    check("multu2_lo", 64'(l), 64'h0003_0000);

    // DIV -7 / 2
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, st, got, h, l, d0);
    check("div_stalls", 64'(st), 64'd33);
    check("div_lo", 64'(l), 64'hFFFF_FFFD);
    check("div_hi", 64'(h), 64'hFFFF_FFFF);
    @(negedge clk);
    check("div_done_pulse", 64'(done_o), 64'd0);
    step(1);

    // DIVU 100 / 7 and the signed overflow case
    run_op(OP_DIVU, 32'd100, 32'd7, st, got, h, l, d0);
    check("divu_lo", 64'(l), 64'd14);
    check("divu_hi", 64'(h), 64'd2);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, got, h, l, d0);
    check("ovf_lo", 64'(l), 64'h8000_0000);
    check("ovf_hi", 64'(h), 64'd0);

    // Reset in the middle of a divide
    drive(1'b1, OP_DIVU, 32'd1000, 32'd3);
    step(5);
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_hi", 64'(hi_o), 64'd0);
    check("midrst_lo", 64'(lo_o), 64'd0);
    step(1);

    // MTHI/MTLO, then a flushed DIV
    drive(1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
    step(1);
    drive(1'b1, OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    step(1);
    drive(1'b1, OP_DIV, 32'd50, 32'd3);
    step(10);
    flush = 1'b1;
    @(negedge clk);
    check("flush_c10_stall", 64'(stall_o), 64'd1);
    step(1);
    flush = 1'b0;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    @(negedge clk);
    check("flush_c11_stall", 64'(stall_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    step(1);
    drive(1'b1, OP_MFHI, 32'd0, 32'd0);
    @(negedge clk);
    check("mfhi", 64'(result_o), 64'h1234_5678);
    step(1);
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    @(negedge clk);
    check("mflo", 64'(result_o), 64'h9ABC_DEF0);
    step(1);

    // Flush while idle suppresses an MTHI write
    drive(1'b1, OP_MTHI, 32'hDEAD_0000, 32'd0);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    @(negedge clk);
    check("flush_idle_hi", 64'(hi_o), 64'h1234_5678);
    step(1);

    // Divide by zero after MTLO
    drive(1'b1, OP_MTLO, 32'hCAFE_BABE, 32'd0);
    step(1);
    run_op(OP_DIVU, 32'h55, 32'd0, st, got, h, l, d0);
    check("div0_stalls", 64'(st), 64'd33);
`ifdef MULDIV_DIV0_FLAG_EN
    check("div0_flag", 64'(d0), 64'd1);
    check("div0_lo", 64'(l), 64'hCAFE_BABE);
    check("div0_hi", 64'(h), 64'h1234_5678);
`else
    check("div0_hi", 64'(h), 64'h55);
    check("div0_lo", 64'(l), 64'hFFFF_FFFF);
`endif

    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
EX-stage execution unit that consumes the 8-bit ALU operation code (`EXE_*_OP` from defines.vh) for the HI/LO instruction group: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU run as multi-cycle operations and stall the pipeline while busy. MFHI/MFLO read data is returned on result_o for the EX result mux.

Parameters:
MUL_CYCLES, 2, busy cycles after the accept cycle for MULT/MULTU (legal range 1..8).
DIV_ITERS, 32, restoring-division iterations. Fixed at 32; do not override.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  synchronous cancel of the in-flight operation (exception or branch squash)
valid_i  in  1  EX-stage instruction valid
alucontrol_i  in  8  operation code (`EXE_*_OP`)
a_i  in  32  rs operand
b_i  in  32  rt operand
stall_o  out  1  pipeline stall request
done_o  out  1  one-cycle pulse when a mul/div result is written
hi_o  out  32  HI register
lo_o  out  32  LO register
result_o  out  32  MFHI → hi_o; MFLO → lo_o; otherwise 0; combinational
div0_o  out  1  present only with MULDIV_DIV0_FLAG_EN

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; hi, lo, stall_o, done_o and div0_o all 0. rst has priority over everything else.
- Priority order: rst > flush > normal operation.
- States: IDLE, MUL, DIV, DONE.
- Accept: in IDLE with valid_i=1, flush=0 and a code in {MULT, MULTU, DIV, DIVU}:
  - latch the code and both operands;
  - stall_o=1 combinationally in that same cycle;
  - move to MUL or DIV.
- MUL state:
  - product is the 64-bit signed product (MULT) or unsigned product (MULTU);
  - the counter runs MUL_CYCLES cycles; on the last one {hi,lo}<=product and state→DONE;
  - stall_o is high for MUL_CYCLES+1 cycles in total (accept cycle included).
- DIV state:
  - MULT/DIV-style signed divide works on absolute values;
  - one restoring iteration per cycle, 32 cycles;
  - the last iteration writes lo=quotient and hi=remainder, with sign fixes applied;
  - quotient is negated if the operand signs differ; remainder takes the sign of the dividend;
  - stall_o is high for 33 cycles in total (accept + 32).
- DONE state:
  - stall_o=0 and done_o=1;
  - hi_o/lo_o already show the new values;
  - valid_i is ignored (the same instruction is still in EX);
  - next state is always IDLE.
- MTHI/MTLO: in IDLE with valid_i=1 and flush=0, hi<=a_i (MTHI) or lo<=a_i (MTLO) at the next edge. No stall. In states other than IDLE these codes are ignored; they cannot occur there because the pipeline is stalled.
- MFHI/MFLO: combinational read with no stall. A value written by MTHI/MTLO is visible from the following cycle.
- Any other code: no effect; stall_o=0.
- Division by zero (no macro): full 33-cycle latency; then hi<=latched a_i and lo<=32'hFFFFFFFF, regardless of signedness.
- Overflow DIV 0x80000000 / -1: lo=0x80000000, hi=0. No trap.
- flush:
  - in MUL or DIV: state→IDLE at the next edge; result discarded; hi/lo unchanged; stall_o=0 from the next cycle; no done_o;
  - in IDLE: suppresses both accept and MTHI/MTLO writes;
  - in DONE: no effect, because the write has already happened.
- rst mid-operation: immediate return to the reset values at the next edge.

Optional Feature:
MULDIV_DIV0_FLAG_EN:
- Defined:
  - div0_o exists;
  - divisor zero on DIV/DIVU is detected at accept;
  - the unit still runs the full 33-cycle sequence;
  - HI/LO are left unchanged;
  - div0_o=1 together with done_o in the DONE cycle.
- Undefined: no div0_o port; the default divide-by-zero result above applies.

Test Plan:
1. Reset, then MULT a=0xFFFFFFFD (-3), b=7, MUL_CYCLES=2 → stall_o high exactly 3 cycles; in the DONE cycle done_o=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Back-to-back MULTU accepted only after DONE→IDLE.
3. DIV a=0xFFFFFFF9 (-7), b=2 → stall_o high exactly 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; done_o high for one cycle.
4. DIVU a=100, b=7 → lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
5. MTHI 0x12345678, MTLO 0x9ABCDEF0, then DIV a=50, b=3 with flush at cycle 10 → stall_o=0 from cycle 11; no done_o; MFHI result_o=0x12345678; MFLO result_o=0x9ABCDEF0.
6. DIVU a=0x55, b=0, after MTLO 0xCAFEBABE:
   - macro off → hi=0x55, lo=0xFFFFFFFF;
   - macro on → div0_o=1 with done_o, lo=0xCAFEBABE unchanged.
